fft_sdf_stage_ctrl: RTL and testbench

//  Sequencer for one radix-2 single-delay-feedback (SDF) FFT stage.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_phase_cnt.sv | 37 +++
 rtl/fft_sdf_stage_ctrl.sv | 143 ++++++++++++++
 tb/tb_fft_sdf_stage_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the SDF FFT stage sequencer.
// Holds the state enum, datapath mode codes and twiddle number format.
package fft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_BFLY,
        ST_TWID,
        ST_DRAIN
    } state_e;

    localparam logic [1:0] MODE_FILL = 2'd0;
    localparam logic [1:0] MODE_BFLY = 2'd1;
    localparam logic [1:0] MODE_TWID = 2'd2;

    localparam int TW_W    = 24;
    localparam int TW_FRAC = 8;

    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fft_phase_cnt.sv
// Enable-gated wrap counter for one half-frame phase.
// tc_o flags the terminal count DELAY-1; an enabled step there wraps to 0.
module fft_phase_cnt #(
    parameter int DELAY = 64,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o  = (cnt_q == LAST);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: fill / butterfly / twiddle / drain.
// Define FFT_CTRL_FRAME_CNT_EN to add the 16-bit frame_cnt output.
import fft_pkg::*;

module fft_sdf_stage_ctrl #(
    parameter int DELAY     = 64,
    parameter int ADDR_W    = 6,
    parameter int TW_STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_last,
    output logic [1:0]        mode,
    output logic [ADDR_W-1:0] tw_addr,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              ovf_err
`ifdef FFT_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int CW = cnt_width(DELAY);

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   ovf_q, ovf_d;

    logic          adv;
    logic          tc;
    logic          tw_en;
    logic [CW-1:0] cnt;
    logic [ADDR_W-1:0] tw_prod;

    fft_phase_cnt #(
        .DELAY (DELAY),
        .CW    (CW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (adv),
        .cnt_o (cnt),
        .tc_o  (tc)
    );

    // Only the low ADDR_W bits of the product matter, so multiply mod 2**ADDR_W.
    assign tw_prod = ADDR_W'(ADDR_W'(cnt) * ADDR_W'(TW_STRIDE));
    assign tw_addr = tw_en ? tw_prod : '0;
    assign busy    = (state_q != ST_IDLE);
    assign ovf_err = ovf_q;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        adv        = 1'b0;
        tw_en      = 1'b0;
        mode       = MODE_FILL;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                adv = in_valid;
                if (in_valid) begin
                    state_d = (DELAY == 1) ? ST_BFLY : ST_FILL;
                end
            end
            ST_FILL: begin
                adv = in_valid;
                if (in_valid && tc) begin
                    state_d = ST_BFLY;
                end
            end
            ST_BFLY: begin
                mode      = MODE_BFLY;
                adv       = in_valid;
                out_valid = in_valid;
                if (in_valid && tc) begin
                    state_d = (last_q || in_last) ? ST_DRAIN : ST_TWID;
                end
            end
            ST_TWID: begin
                mode      = MODE_TWID;
                tw_en     = 1'b1;
                adv       = in_valid;
                out_valid = in_valid;
                if (in_valid && tc) begin
                    state_d = ST_BFLY;
                end
            end
            ST_DRAIN: begin
                mode      = MODE_TWID;
                tw_en     = 1'b1;
                adv       = 1'b1;
                out_valid = 1'b1;
                if (tc) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                    last_d     = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (in_valid && in_last &&
            (state_q == ST_FILL || state_q == ST_BFLY || state_q == ST_TWID)) begin
            last_d = 1'b1;
        end
    end

    // Samples arriving while draining are dropped; only the error flag records them.
    assign ovf_d = ovf_q | ((state_q == ST_DRAIN) && in_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef FFT_CTRL_FRAME_CNT_EN
    logic [15:0] fcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else if (state_q == ST_BFLY && in_valid && tc) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Directed self-checking bench for fft_sdf_stage_ctrl at DELAY=64, ADDR_W=6.
// Set FFT_CTRL_FRAME_CNT_EN to also check the frame counter.
module tb_fft_sdf_stage_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_last;
    logic [1:0] mode;
    logic [5:0] tw_addr;
    logic       out_valid;
    logic       busy;
    logic       frame_done;
    logic       ovf_err;
`ifdef FFT_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int n_cmp;
    int n_err;

    // {mode, tw_addr, out_valid, busy, frame_done}
    logic [10:0] obs;
    logic [10:0] exp_v;
    assign obs = {mode, tw_addr, out_valid, busy, frame_done};

    fft_sdf_stage_ctrl #(
        .DELAY     (64),
        .ADDR_W    (6),
        .TW_STRIDE (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .mode       (mode),
        .tw_addr    (tw_addr),
        .out_valid  (out_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .ovf_err    (ovf_err)
`ifdef FFT_CTRL_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic l);
        @(negedge clk);
        in_valid = v;
        in_last  = l;
        #2;
    endtask

    task automatic do_reset;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    task automatic test_reset;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        #23;
        exp_v = {2'd0, 6'd0, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_outputs got %h want %h", obs, exp_v);
        end
        n_cmp++;
        if (ovf_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf got %b want 0", ovf_err);
        end
`ifdef FFT_CTRL_FRAME_CNT_EN
        n_cmp++;
        if (frame_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL reset_idle c=%0d got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic run_drain(input string tag, input int ovf_at);
        for (int j = 0; j < 64; j++) begin
            drive(j == ovf_at, 1'b0);
            exp_v = {2'd2, 6'(j), 1'b1, 1'b1, (j == 63)};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL %s drain j=%0d got %h want %h", tag, j, obs, exp_v);
            end
            if (ovf_at >= 0) begin
                n_cmp++;
                if (ovf_err !== (j > ovf_at)) begin
                    n_err++;
                    $display("FAIL %s ovf j=%0d got %b want %b", tag, j, ovf_err, (j > ovf_at));
                end
            end
        end
        drive(1'b0, 1'b0);
        exp_v = {2'd0, 6'd0, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s post_idle got %h want %h", tag, obs, exp_v);
        end
    endtask

    task automatic run_frame(input string tag);
        for (int i = 1; i <= 128; i++) begin
            drive(1'b1, i == 128);
            exp_v = (i <= 64) ? {2'd0, 6'd0, 1'b0, (i != 1), 1'b0}
                              : {2'd1, 6'd0, 1'b1, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL %s sample=%0d got %h want %h", tag, i, obs, exp_v);
            end
        end
    endtask

    task automatic test_single_frame;
        do_reset();
        run_frame("single");
        run_drain("single", -1);
    endtask

    task automatic test_streaming;
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            drive(1'b1, i == 256);
            if (i <= 64)
                exp_v = {2'd0, 6'd0, 1'b0, (i != 1), 1'b0};
            else if (i <= 128 || i > 192)
                exp_v = {2'd1, 6'd0, 1'b1, 1'b1, 1'b0};
            else
                exp_v = {2'd2, 6'(i - 129), 1'b1, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL stream sample=%0d got %h want %h", i, obs, exp_v);
            end
        end
        run_drain("stream", -1);
`ifdef FFT_CTRL_FRAME_CNT_EN
        n_cmp++;
        if (frame_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL stream_frame_cnt got %0d want 2", frame_cnt);
        end
`endif
    endtask

    task automatic test_gaps;
        do_reset();
        for (int i = 1; i <= 64; i++) drive(1'b1, 1'b0);
        for (int k = 0; k < 64; k++) begin
            drive(1'b1, 1'b0);
            exp_v = {2'd1, 6'd0, 1'b1, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL gap_bfly_v k=%0d got %h want %h", k, obs, exp_v);
            end
            drive(1'b0, 1'b0);
            exp_v = (k == 63) ? {2'd2, 6'd0, 1'b0, 1'b1, 1'b0}
                              : {2'd1, 6'd0, 1'b0, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL gap_bfly_0 k=%0d got %h want %h", k, obs, exp_v);
            end
        end
        for (int k = 0; k < 64; k++) begin
            drive(1'b1, 1'b0);
            exp_v = {2'd2, 6'(k), 1'b1, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL gap_twid_v k=%0d got %h want %h", k, obs, exp_v);
            end
            drive(1'b0, 1'b0);
            exp_v = (k == 63) ? {2'd1, 6'd0, 1'b0, 1'b1, 1'b0}
                              : {2'd2, 6'(k + 1), 1'b0, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL gap_twid_0 k=%0d got %h want %h", k, obs, exp_v);
            end
        end
        for (int i = 1; i <= 64; i++) begin
            drive(1'b1, i == 64);
            exp_v = {2'd1, 6'd0, 1'b1, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL gap_bfly2 i=%0d got %h want %h", i, obs, exp_v);
            end
        end
        run_drain("gap", -1);
    endtask

    task automatic test_overflow;
        do_reset();
        run_frame("ovf1");
        run_drain("ovf1", 10);
        n_cmp++;
        if (ovf_err !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky_idle got %b want 1", ovf_err);
        end
        run_frame("ovf2");
        run_drain("ovf2", -1);
        n_cmp++;
        if (ovf_err !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky_end got %b want 1", ovf_err);
        end
    endtask

    task automatic test_midop_reset;
        do_reset();
        for (int i = 1; i <= 94; i++) drive(1'b1, 1'b0);
        exp_v = {2'd1, 6'd0, 1'b1, 1'b1, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL midop_pre got %h want %h", obs, exp_v);
        end
        #1;
        rst_n = 1'b0;
        #1;
        exp_v = {2'd0, 6'd0, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL midop_async got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("midop");
        run_drain("midop", -1);
        n_cmp++;
        if (ovf_err !== 1'b0) begin
            n_err++;
            $display("FAIL midop_ovf got %b want 0", ovf_err);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_frame();
        test_streaming();
        test_gaps();
        test_overflow();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
